// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift the frame out on
// device clock falls, then check the device ACK. Both lines are open-drain (0 or Z).
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        PS2_CLOCK,
  inout  wire        PS2_DATA,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                       : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned FRAME_W = 10;
  localparam int unsigned IDX_W   = 4;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_INHIBIT  = 3'd1;
  localparam logic [2:0] S_REQ      = 3'd2;
  localparam logic [2:0] S_SEND     = 3'd3;
  localparam logic [2:0] S_ACK_WAIT = 3'd4;
  localparam logic [2:0] S_RELEASE  = 3'd5;

  logic [2:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [FRAME_W-1:0] r_shift;
  logic               r_clk_oe;
  logic               r_dat_oe;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic               r_clk_meta;
  logic               r_clk_sync;
  logic               r_clk_prev;
  logic               r_dat_meta;
  logic               r_dat_sync;

  logic [2:0]         w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [FRAME_W-1:0] w_shift_nxt;
  logic               w_clk_oe_nxt;
  logic               w_dat_oe_nxt;
  logic               w_done_nxt;
  logic               w_error_nxt;
  logic               w_fall;
  logic               w_active;
  logic               w_timeout;
  logic               w_inh_done;

  // Open-drain drive: only ever pull low or release.
  assign PS2_CLOCK = r_clk_oe ? 1'b0 : 1'bz;
  assign PS2_DATA  = r_dat_oe ? 1'b0 : 1'bz;

  assign tx_busy  = r_busy;
  assign tx_done  = r_done;
  assign tx_error = r_error;

  assign w_fall     = r_clk_prev & ~r_clk_sync;
  assign w_active   = (r_state == S_REQ) || (r_state == S_SEND) ||
                      (r_state == S_ACK_WAIT) || (r_state == S_RELEASE);
  assign w_cnt_inc  = (r_cnt == CNT_W'(CNT_MAX)) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_timeout  = (r_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_inh_done = (r_cnt >= CNT_W'(INHIBIT_CYCLES - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_shift_nxt  = r_shift;
    w_clk_oe_nxt = r_clk_oe;
    w_dat_oe_nxt = r_dat_oe;
    w_done_nxt   = 1'b0;
    w_error_nxt  = 1'b0;

    // Device-clock watchdog: cleared by every falling edge while a transfer is live.
    if (w_active) begin
      w_cnt_nxt = w_fall ? '0 : w_cnt_inc;
    end

    unique case (r_state)
      S_IDLE: begin
        w_clk_oe_nxt = 1'b0;
        w_dat_oe_nxt = 1'b0;
        if (tx_start) begin
          w_shift_nxt  = {1'b1, ~^tx_data, tx_data};
          w_cnt_nxt    = '0;
          w_idx_nxt    = '0;
          w_clk_oe_nxt = 1'b1;
          w_state_nxt  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (w_inh_done) begin
          w_cnt_nxt    = '0;
          w_clk_oe_nxt = 1'b0;
          w_dat_oe_nxt = 1'b1;
          w_state_nxt  = S_REQ;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_REQ: begin
        if (w_fall) begin
          w_dat_oe_nxt = ~r_shift[0];
          w_idx_nxt    = IDX_W'(1);
          w_state_nxt  = S_SEND;
        end
      end
      S_SEND: begin
        if (w_fall) begin
          w_dat_oe_nxt = ~r_shift[r_idx];
          if (r_idx == IDX_W'(FRAME_W - 1)) begin
            w_state_nxt = S_ACK_WAIT;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      S_ACK_WAIT: begin
        if (w_fall) begin
          w_dat_oe_nxt = 1'b0;
          if (!r_dat_sync) begin
            w_state_nxt = S_RELEASE;
          end else begin
            w_error_nxt = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_RELEASE: begin
        if (r_clk_sync && r_dat_sync) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_clk_oe_nxt = 1'b0;
        w_dat_oe_nxt = 1'b0;
        w_state_nxt  = S_IDLE;
      end
    endcase

    // A completed release beats a watchdog expiry landing in the same cycle.
    if (w_active && !w_fall && w_timeout && !w_done_nxt) begin
      w_clk_oe_nxt = 1'b0;
      w_dat_oe_nxt = 1'b0;
      w_error_nxt  = 1'b1;
      w_state_nxt  = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_clk_oe   <= 1'b0;
      r_dat_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_clk_oe   <= w_clk_oe_nxt;
      r_dat_oe   <= w_dat_oe_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
      r_clk_meta <= PS2_CLOCK;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_dat_meta <= PS2_DATA;
      r_dat_sync <= r_dat_meta;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: PS/2 keyboard model on pulled-up lines plus two scoreboards,
// one for received frames and one for the done/error outcome of each request.
module tb_ps2_host_tx;

  localparam int INH        = 20;
  localparam int TO         = 2000;
  localparam int HALF       = 20;
  localparam int DEV_ACK    = 0;
  localparam int DEV_NOACK  = 1;
  localparam int DEV_SILENT = 2;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  wire ps2_clk;
  wire ps2_data;

  logic dev_clk_low;
  logic dev_dat_low;
  logic dev_abort;
  int   dev_mode;
  int   dev_rises;

  int total;
  int bad;

  bit         exp_q[$];
  logic [9:0] frame_q[$];

  pullup (ps2_clk);
  pullup (ps2_data);
  assign ps2_clk  = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_data = dev_dat_low ? 1'b0 : 1'bz;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .PS2_CLOCK(ps2_clk),
    .PS2_DATA (ps2_data),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_error (tx_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Half a device clock period; bails out early (lines released) when aborted.
  task automatic half_wait(output bit ok);
    ok = 1'b1;
    for (int i = 0; i < HALF; i++) begin
      @(negedge clk);
      if (dev_abort) begin
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        ok = 1'b0;
        return;
      end
    end
  endtask

  // Keyboard model: on a request (data low, clock high) clock 11 times, sample on rises.
  initial begin : device_model
    bit         ok;
    logic [9:0] bits;
    logic [9:0] want;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    dev_rises   = 0;
    forever begin
      @(negedge clk);
      if (!dev_abort && !reset && dev_mode != DEV_SILENT &&
          ps2_clk === 1'b1 && ps2_data === 1'b0) begin
        bits      = '0;
        dev_rises = 0;
        half_wait(ok);
        for (int k = 0; k < 11; k++) begin
          if (!ok) break;
          if (k == 10 && dev_mode == DEV_ACK) dev_dat_low = 1'b1;
          dev_clk_low = 1'b1;
          half_wait(ok);
          if (!ok) break;
          dev_clk_low = 1'b0;
          dev_rises   = dev_rises + 1;
          if (k < 10) bits[k] = ps2_data;
          half_wait(ok);
        end
        dev_dat_low = 1'b0;
        dev_clk_low = 1'b0;
        if (ok) begin
          if (frame_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: actual=%0h expected=none", bits);
          end else begin
            want = frame_q.pop_front();
            check("frame_bits", 32'(bits), 32'(want));
          end
        end
      end
    end
  end

  // Outcome scoreboard: every done/error pulse must match the oldest expected outcome.
  initial begin : monitor
    bit prev_busy;
    bit e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_done === 1'b1 || tx_error === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: actual done=%0b error=%0b expected=none",
                   tx_done, tx_error);
        end else begin
          e = exp_q.pop_front();
          check("outcome_done", 32'(tx_done), 32'(e));
          check("outcome_error", 32'(tx_error), 32'(!e));
        end
        check("busy_falls_with_pulse", 32'({prev_busy, tx_busy}), 32'(2'b10));
      end
      prev_busy = tx_busy;
    end
  end

  // Reference: LSB-first data, odd parity (data ones + parity is odd), stop = 1.
  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    bit par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b};
  endfunction

  task automatic send(input logic [7:0] b, input int mode, input bit poke);
    int n;
    dev_mode = mode;
    exp_q.push_back(mode == DEV_ACK);
    if (mode != DEV_SILENT) frame_q.push_back(ref_frame(b));
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    check("busy_after_accept", 32'(tx_busy), 32'd1);
    n = 0;
    while (ps2_clk === 1'b0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_cycles", 32'(n), 32'(INH));
    check("request_data_low", 32'(ps2_data), 32'd0);
    if (mode == DEV_SILENT) begin
      n = 0;
      while (tx_error !== 1'b1 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      check("timeout_latency", 32'(n), 32'(TO));
      check("busy_after_timeout", 32'(tx_busy), 32'd0);
    end else begin
      n = 0;
      while (tx_busy === 1'b1 && n < 5000) begin
        tx_start = (poke && n == 100);
        if (poke && n == 100) tx_data = 8'hFF;
        @(negedge clk);
        n++;
      end
      tx_start = 1'b0;
      check("transfer_ends", 32'(tx_busy), 32'd0);
    end
    repeat (60) @(negedge clk);
    check("clock_released", 32'(ps2_clk), 32'd1);
    check("data_released", 32'(ps2_data), 32'd1);
    check("idle_not_busy", 32'(tx_busy), 32'd0);
  endtask

  task automatic reset_mid_transfer();
    int n;
    dev_mode  = DEV_ACK;
    dev_rises = 0;
    tx_data   = 8'h55;
    tx_start  = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    n = 0;
    while (dev_rises < 4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("reached_four_clocks", 32'(dev_rises), 32'd4);
    check("bit3_driven_low", 32'(ps2_data), 32'd0);
    reset     = 1'b1;
    dev_abort = 1'b1;
    @(negedge clk);
    check("rst_clock_released", 32'(ps2_clk), 32'd1);
    check("rst_data_released", 32'(ps2_data), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_error", 32'(tx_error), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    dev_abort = 1'b0;
    @(negedge clk);
  endtask

  initial begin : stimulus
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    tx_start  = 1'b0;
    tx_data   = 8'h00;
    dev_abort = 1'b0;
    dev_mode  = DEV_SILENT;
    repeat (5) @(negedge clk);
    check("reset_busy", 32'(tx_busy), 32'd0);
    check("reset_done", 32'(tx_done), 32'd0);
    check("reset_error", 32'(tx_error), 32'd0);
    check("reset_clock_z", 32'(ps2_clk), 32'd1);
    check("reset_data_z", 32'(ps2_data), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    send(8'hED, DEV_ACK, 1'b0);
    send(8'hF4, DEV_ACK, 1'b1);
    send(8'($urandom), DEV_NOACK, 1'b0);
    send(8'($urandom), DEV_SILENT, 1'b0);
    reset_mid_transfer();
    send(8'hED, DEV_ACK, 1'b0);
    for (int i = 0; i < 6; i++) begin
      send(8'($urandom), ($urandom_range(0, 3) == 0) ? DEV_NOACK : DEV_ACK, 1'b0);
    end

    repeat (20) @(negedge clk);
    check("outcomes_all_seen", 32'(exp_q.size()), 32'd0);
    check("frames_all_seen", 32'(frame_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
